// File: rtl/pp_input_conditioner.sv
// Input conditioning for the ping-pong counter: synchronizes and debounces the
// board controls, divides clk into a count tick and drives the counter's inputs.
module pp_input_conditioner #(
   parameter int TICK_DIV    = 16777216,
   parameter int DB_LEN      = 4,
   parameter int STARTUP_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_flip,
   input  logic       btn_reset,
   input  logic       sw_enable,
   input  logic [3:0] sw_max,
   input  logic [3:0] sw_min,
   output logic       enable,
   output logic       flip,
   output logic       cnt_rst_n,
   output logic [3:0] max,
   output logic [3:0] min
);

   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int ST_W   = $clog2(STARTUP_LEN);

   // Bit order of the debounced controls: 0 = flip, 1 = reset, 2 = enable.
   localparam int B_FLIP = 0;
   localparam int B_RST  = 1;
   localparam int B_EN   = 2;

   logic [2:0]              raw_m, raw_s;
   logic [3:0]              max_m, max_s, min_m, min_s;
   logic [2:0][DB_LEN-1:0]  sh, sh_nxt;
   logic [2:0]              db, db_nxt;
   logic                    db_flip_d;
   logic                    flip_pend;
   logic [ST_W-1:0]         st_cnt;
   logic                    st_done;
   logic                    cnt_rst_q;
   logic [TICK_W-1:0]       tick_cnt;
   logic                    tick;
   logic                    cnt_rst_n_nxt;
   logic                    flip_rise;
   logic                    emit_flip;

   // The debounced level is decided from the shift register's next contents,
   // so a clean edge shows up 2 + DB_LEN cycles after it reaches the pin.
   always_comb begin
      sh_nxt = sh;
      db_nxt = db;
      for (int i = 0; i < 3; i++) begin
         sh_nxt[i] = {sh[i][DB_LEN-2:0], raw_s[i]};
         if (&sh_nxt[i])
            db_nxt[i] = 1'b1;
         else if (~|sh_nxt[i])
            db_nxt[i] = 1'b0;
      end
   end

   assign st_done       = (st_cnt == ST_W'(STARTUP_LEN - 1));
   assign tick          = (tick_cnt == TICK_W'(TICK_DIV - 1));
   assign cnt_rst_n_nxt = st_done & ~db[B_RST];
   assign flip_rise     = db[B_FLIP] & ~db_flip_d;
   assign emit_flip     = tick & db[B_EN] & flip_pend & cnt_rst_n_nxt;

   // NOTE: every register, including the debounce shift registers, is cleared
   // by rst so the block leaves reset in a known state with no stray presses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raw_m     <= '0;
         raw_s     <= '0;
         max_m     <= '0;
         max_s     <= '0;
         min_m     <= '0;
         min_s     <= '0;
         sh        <= '0;
         db        <= '0;
         db_flip_d <= 1'b0;
         flip_pend <= 1'b0;
         st_cnt    <= '0;
         cnt_rst_n <= 1'b0;
         cnt_rst_q <= 1'b0;
         tick_cnt  <= '0;
         enable    <= 1'b0;
         flip      <= 1'b0;
         max       <= '0;
         min       <= '0;
      end else begin
         raw_m     <= {sw_enable, btn_reset, btn_flip};
         raw_s     <= raw_m;
         max_m     <= sw_max;
         max_s     <= max_m;
         min_m     <= sw_min;
         min_s     <= min_m;
         sh        <= sh_nxt;
         db        <= db_nxt;
         db_flip_d <= db[B_FLIP];

         if (!st_done)
            st_cnt <= st_cnt + ST_W'(1);
         cnt_rst_n <= cnt_rst_n_nxt;
         cnt_rst_q <= cnt_rst_n;

         // Tick phase starts on the first cycle the counter is out of reset.
         if (!cnt_rst_n || !cnt_rst_q || tick)
            tick_cnt <= '0;
         else
            tick_cnt <= tick_cnt + TICK_W'(1);

         enable <= tick & db[B_EN] & cnt_rst_n_nxt;
         flip   <= emit_flip;

         if (!cnt_rst_n)
            flip_pend <= 1'b0;
         else if (flip_rise)
            flip_pend <= 1'b1;
         else if (emit_flip)
            flip_pend <= 1'b0;

         if (!cnt_rst_n || tick) begin
            max <= max_s;
            min <= min_s;
         end
      end
   end

endmodule

// File: tb/tb_pp_input_conditioner.sv
// Scoreboard bench for pp_input_conditioner: stimulus queues the expected
// enable pulses, a negedge monitor matches them as the DUT produces them.
module tb_pp_input_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_flip, btn_reset, sw_enable;
   logic [3:0] sw_max, sw_min;
   logic       enable, flip, cnt_rst_n;
   logic [3:0] max, min;

   pp_input_conditioner #(.TICK_DIV(8), .DB_LEN(4), .STARTUP_LEN(4)) dut (
      .clk(clk), .rst(rst), .btn_flip(btn_flip), .btn_reset(btn_reset),
      .sw_enable(sw_enable), .sw_max(sw_max), .sw_min(sw_min),
      .enable(enable), .flip(flip), .cnt_rst_n(cnt_rst_n), .max(max), .min(min)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       flip;
      logic [3:0] mx;
      logic [3:0] mn;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   rel, e0, r2, rel2;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_en(input int c, input logic f, input logic [3:0] mx, input logic [3:0] mn);
      exp_t e;
      e.cyc = c; e.flip = f; e.mx = mx; e.mn = mn;
      q.push_back(e);
   endtask

   task automatic at(input int c);
      if (c < cyc) begin
         n_tests++;
         n_fail++;
         $display("FAIL schedule: cycle %0d already past (now %0d)", c, cyc);
      end else begin
         while (cyc != c) @(negedge clk);
      end
   endtask

   function automatic int ecyc(input int k);
      return e0 + 8 * k;
   endfunction

   // Monitor: matches every enable pulse against the head of the queue.
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL en_missing: no enable at cycle %0d, expected 1", e.cyc);
      end
      if (enable) begin
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            check($sformatf("en_flip@%0d", cyc), flip, e.flip);
            check($sformatf("en_max@%0d", cyc), max, e.mx);
            check($sformatf("en_min@%0d", cyc), min, e.mn);
         end else begin
            n_tests++;
            n_fail++;
            $display("FAIL en_unexpected: enable=1 at cycle %0d, expected 0", cyc);
         end
      end else if (flip) begin
         n_tests++;
         n_fail++;
         $display("FAIL flip_alone: flip=1 without enable at cycle %0d, expected 0", cyc);
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; btn_flip = 1'b0; btn_reset = 1'b0; sw_enable = 1'b1;
      sw_max = 4'd9; sw_min = 4'd2;
      repeat (3) @(negedge clk);
      check("rst_enable", enable, 0);
      check("rst_flip", flip, 0);
      check("rst_cnt_rst_n", cnt_rst_n, 0);
      check("rst_max", max, 0);
      check("rst_min", min, 0);

      // Startup
      rst = 1'b0;
      rel = cyc;
      e0  = rel + 13;
      expect_en(ecyc(0), 0, 9, 2);
      expect_en(ecyc(1), 0, 9, 2);
      at(rel + 2); check("max_before_c3", max, 0);
      at(rel + 3); check("max_c3", max, 9);
      check("min_c3", min, 2);
      check("cnt_rst_n_c3", cnt_rst_n, 0);
      at(rel + 4); check("cnt_rst_n_c4", cnt_rst_n, 1);

      // Bouncing flip: never four equal samples
      expect_en(ecyc(2), 0, 9, 2);
      expect_en(ecyc(3), 0, 9, 2);
      for (int i = 0; i < 10; i++) begin
         at(ecyc(1) + i);
         btn_flip = (i % 2 == 0);
      end
      at(ecyc(1) + 10); btn_flip = 1'b0;

      // Clean 6-cycle press, latest start that still makes the next tick
      expect_en(ecyc(4), 1, 9, 2);
      at(ecyc(3));     btn_flip = 1'b1;
      at(ecyc(3) + 6); btn_flip = 1'b0;

      // Press whose flip_pend sets on a tick cycle waits one more tick
      expect_en(ecyc(5), 0, 9, 2);
      expect_en(ecyc(6), 0, 9, 2);
      expect_en(ecyc(7), 1, 9, 2);
      at(ecyc(5) + 1); btn_flip = 1'b1;
      at(ecyc(5) + 7); btn_flip = 1'b0;

      // Enable off: ticks swallowed, three presses collapse into one flip
      at(ecyc(7) + 1); sw_enable = 1'b0;
      for (int j = 0; j < 3; j++) begin
         at(ecyc(8) + 12 * j);     btn_flip = 1'b1;
         at(ecyc(8) + 12 * j + 5); btn_flip = 1'b0;
      end
      expect_en(ecyc(13), 1, 9, 2);
      expect_en(ecyc(14), 0, 9, 2);
      at(ecyc(12)); sw_enable = 1'b1;

      // Bounds hold between ticks
      expect_en(ecyc(15), 0, 12, 2);
      at(ecyc(14) + 3); sw_max = 4'd12;
      at(ecyc(15) - 1); check("max_hold_midperiod", max, 9);

      // Reset button held 12 cycles
      expect_en(ecyc(16), 0, 12, 2);
      at(ecyc(15) + 2);  btn_reset = 1'b1;
      at(ecyc(16));      check("cnt_rst_n_before_fall", cnt_rst_n, 1);
      at(ecyc(16) + 1);  check("cnt_rst_n_held", cnt_rst_n, 0);
      at(ecyc(16) + 3);  sw_min = 4'd5;
      at(ecyc(16) + 6);  check("min_track_in_reset", min, 5);
      check("max_in_reset", max, 12);
      at(ecyc(15) + 14); btn_reset = 1'b0;
      r2 = ecyc(15) + 21;
      expect_en(r2 + 9, 0, 12, 5);
      at(r2 - 1); check("cnt_rst_n_before_rise", cnt_rst_n, 0);
      at(r2);     check("cnt_rst_n_rise", cnt_rst_n, 1);

      // rst mid-operation drops a pending flip
      at(r2 + 9);  btn_flip = 1'b1;
      at(r2 + 15); btn_flip = 1'b0;
      at(r2 + 16); rst = 1'b1;
      #1;
      check("midrst_enable", enable, 0);
      check("midrst_flip", flip, 0);
      check("midrst_cnt_rst_n", cnt_rst_n, 0);
      check("midrst_max", max, 0);
      check("midrst_min", min, 0);
      repeat (3) @(negedge clk);
      rst  = 1'b0;
      rel2 = cyc;
      expect_en(rel2 + 13, 0, 12, 5);
      expect_en(rel2 + 21, 0, 12, 5);
      at(rel2 + 4);  check("cnt_rst_n_restart", cnt_rst_n, 1);
      at(rel2 + 26); check("queue_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
